// File: rtl/instr_reg_reader.sv
// Read-side sequencer for the instruction register.
// Walks entries, recomputes each result and streams it out with a mismatch flag.
module instr_reg_reader #(
  parameter int DEPTH = 32,
  parameter int PTR_W = 5,
  parameter int OP_W  = 32,
  parameter int RES_W = 64,
  parameter int OPC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PTR_W-1:0] first_ptr,
  input  logic [PTR_W:0]   count,
  output logic [PTR_W-1:0] read_pointer,
  input  logic [OPC_W-1:0] iw_opcode,
  input  logic [OP_W-1:0]  iw_op_a,
  input  logic [OP_W-1:0]  iw_op_b,
  input  logic [RES_W-1:0] iw_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PTR_W-1:0] out_ptr,
  output logic [OPC_W-1:0] out_opcode,
  output logic [OP_W-1:0]  out_op_a,
  output logic [OP_W-1:0]  out_op_b,
  output logic [RES_W-1:0] out_result,
  output logic [RES_W-1:0] out_expected,
  output logic             out_mismatch,
  output logic             busy,
  output logic             done,
  output logic [PTR_W:0]   err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPT,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [OPC_W-1:0] OPC_PASSA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_PASSB = OPC_W'(2);
  localparam logic [OPC_W-1:0] OPC_ADD   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_SUB   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OPC_MULT  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OPC_DIV   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OPC_MOD   = OPC_W'(7);
  localparam logic [PTR_W:0]   ERR_MAX   = '1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

  state_t state;
  state_t state_nx;

  logic [PTR_W:0]   rem;
  logic [PTR_W-1:0] ptr_inc;
  logic             accept;

  logic signed [RES_W-1:0] a_x;
  logic signed [RES_W-1:0] b_x;
  logic signed [RES_W-1:0] exp_c;

  assign accept  = out_valid && out_ready;
  assign ptr_inc = (read_pointer == PTR_LAST) ? '0 : read_pointer + 1'b1;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign out_mismatch = (out_expected != out_result);

  // Operands are signed; widen first so every op is exact in RES_W.
  assign a_x = {{(RES_W-OP_W){iw_op_a[OP_W-1]}}, iw_op_a};
  assign b_x = {{(RES_W-OP_W){iw_op_b[OP_W-1]}}, iw_op_b};

  always_comb begin
    exp_c = '0;
    unique case (iw_opcode)
      OPC_PASSA: exp_c = a_x;
      OPC_PASSB: exp_c = b_x;
      OPC_ADD:   exp_c = a_x + b_x;
      OPC_SUB:   exp_c = a_x - b_x;
      OPC_MULT:  exp_c = a_x * b_x;
      OPC_DIV:   if (b_x != '0) exp_c = a_x / b_x;
      OPC_MOD:   if (b_x != '0) exp_c = a_x % b_x;
      default:   exp_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = (count == '0) ? S_DONE : S_ADDR;
      S_ADDR: state_nx = S_CAPT;
      S_CAPT: state_nx = S_OUT;
      S_OUT:  if (accept) state_nx = (rem == 1) ? S_DONE : S_ADDR;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_pointer <= '0;
      rem          <= '0;
      out_valid    <= 1'b0;
      out_ptr      <= '0;
      out_opcode   <= '0;
      out_op_a     <= '0;
      out_op_b     <= '0;
      out_result   <= '0;
      out_expected <= '0;
      err_count    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            rem       <= count;
            err_count <= '0;
            if (count != '0) read_pointer <= first_ptr;
          end
        end
        S_CAPT: begin
          out_valid    <= 1'b1;
          out_ptr      <= read_pointer;
          out_opcode   <= iw_opcode;
          out_op_a     <= iw_op_a;
          out_op_b     <= iw_op_b;
          out_result   <= iw_result;
          out_expected <= exp_c;
        end
        S_OUT: begin
          if (accept) begin
            out_valid <= 1'b0;
            if (out_mismatch && err_count != ERR_MAX)
              err_count <= err_count + 1'b1;
            if (rem != 1) begin
              read_pointer <= ptr_inc;
              rem          <= rem - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_reg_reader.sv
// Directed bench for instr_reg_reader.
// A small register-file model feeds the read port combinationally.
module tb_instr_reg_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_ptr;
  logic [5:0]  count;
  logic [4:0]  read_pointer;
  logic [3:0]  iw_opcode;
  logic [31:0] iw_op_a;
  logic [31:0] iw_op_b;
  logic [63:0] iw_result;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_ptr;
  logic [3:0]  out_opcode;
  logic [31:0] out_op_a;
  logic [31:0] out_op_b;
  logic [63:0] out_result;
  logic [63:0] out_expected;
  logic        out_mismatch;
  logic        busy;
  logic        done;
  logic [5:0]  err_count;

  logic [3:0]  m_opc [32];
  logic [31:0] m_a   [32];
  logic [31:0] m_b   [32];
  logic [63:0] m_r   [32];

  int n_checks = 0;
  int n_fail   = 0;

  int     beat_ptr [$];
  longint beat_exp [$];
  bit     beat_mm  [$];

  always #5 clk = ~clk;

  assign iw_opcode = m_opc[read_pointer];
  assign iw_op_a   = m_a[read_pointer];
  assign iw_op_b   = m_b[read_pointer];
  assign iw_result = m_r[read_pointer];

  instr_reg_reader dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .first_ptr(first_ptr),
    .count(count),
    .read_pointer(read_pointer),
    .iw_opcode(iw_opcode),
    .iw_op_a(iw_op_a),
    .iw_op_b(iw_op_b),
    .iw_result(iw_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ptr(out_ptr),
    .out_opcode(out_opcode),
    .out_op_a(out_op_a),
    .out_op_b(out_op_b),
    .out_result(out_result),
    .out_expected(out_expected),
    .out_mismatch(out_mismatch),
    .busy(busy),
    .done(done),
    .err_count(err_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int idx, input int opc,
                           input int a, input int b,
                           input longint res);
    m_opc[idx] = 4'(opc);
    m_a[idx]   = a;
    m_b[idx]   = b;
    m_r[idx]   = res;
  endtask

  // Starts a pass and records accepted beats until done or a cycle budget.
  task automatic run_collect(input int first, input int cnt,
                             input int inject_at, output bit got_done);
    got_done = 1'b0;
    beat_ptr.delete();
    beat_exp.delete();
    beat_mm.delete();
    first_ptr = 5'(first);
    count     = 6'(cnt);
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (out_valid && out_ready) begin
        beat_ptr.push_back(int'(out_ptr));
        beat_exp.push_back(longint'(out_expected));
        beat_mm.push_back(out_mismatch);
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      start = (i == inject_at);
      if (i == inject_at) begin
        first_ptr = 5'd20;
        count     = 6'd1;
      end
      tick();
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_done: got %0b%0b want 00", busy, done);
    end
    n_checks++;
    if (read_pointer !== 5'd0 || err_count !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_ptr_err: got %0d/%0d want 0/0", read_pointer, err_count);
    end
    n_checks++;
    if (out_expected !== 64'd0 || out_mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_exp: got %0d/%0b want 0/0", out_expected, out_mismatch);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_add();
    set_entry(0, 3, 5, -7, -2);
    out_ready = 1'b1;
    first_ptr = 5'd0;
    count     = 6'd1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_c1: got busy=%0b valid=%0b want 1/0", busy, out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_c2_valid: got %0b want 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ptr !== 5'd0) begin
      n_fail++; $display("FAIL add_c3_valid: got %0b/%0d want 1/0", out_valid, out_ptr);
    end
    n_checks++;
    if (longint'(out_expected) !== -64'sd2 || out_mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL add_expected: got %0d/%0b want -2/0",
               longint'(out_expected), out_mismatch);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_done: got done=%0b valid=%0b want 1/0", done, out_valid);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL add_idle: got done=%0b busy=%0b want 0/0", done, busy);
    end
  endtask

  task automatic test_arith();
    bit     got;
    longint ex [8] = '{64'sd4294967294, -64'sd3, -64'sd1, 64'sd12,
                       64'sd0, -64'sd2147483649, 64'sd0, -64'sd1};
    bit     mm [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    set_entry(3, 5, 32'h7FFFFFFF, 2, 64'h00000000FFFFFFFE);
    set_entry(4, 6, -7, 2, -3);
    set_entry(5, 7, -7, 2, -1);
    set_entry(6, 5, 3, 4, 0);
    set_entry(7, 6, 5, 0, 0);
    set_entry(8, 4, 32'h80000000, 1, -64'sd2147483649);
    set_entry(9, 12, 9, 9, 0);
    set_entry(10, 2, 1, -1, -1);
    out_ready = 1'b1;
    run_collect(3, 8, -1, got);
    n_checks++;
    if (!got || beat_ptr.size() != 8) begin
      n_fail++; $display("FAIL arith_beats: got %0d done=%0b want 8/1", beat_ptr.size(), got);
    end
    for (int i = 0; i < 8 && i < beat_ptr.size(); i++) begin
      n_checks++;
      if (beat_ptr[i] != 3 + i || beat_exp[i] !== ex[i] || beat_mm[i] !== mm[i]) begin
        n_fail++;
        $display("FAIL arith_beat%0d: got ptr=%0d exp=%0d mm=%0b want %0d/%0d/%0b",
                 i, beat_ptr[i], beat_exp[i], beat_mm[i], 3 + i, ex[i], mm[i]);
      end
    end
    n_checks++;
    if (err_count !== 6'd1) begin
      n_fail++; $display("FAIL arith_err_count: got %0d want 1", err_count);
    end
  endtask

  task automatic test_wrap();
    bit got;
    int ptrs [4] = '{30, 31, 0, 1};
    for (int i = 0; i < 4; i++) set_entry(ptrs[i], 1, 100 + i, 0, 100 + i);
    out_ready = 1'b1;
    run_collect(30, 4, -1, got);
    n_checks++;
    if (!got || beat_ptr.size() != 4) begin
      n_fail++; $display("FAIL wrap_beats: got %0d done=%0b want 4/1", beat_ptr.size(), got);
    end
    for (int i = 0; i < 4 && i < beat_ptr.size(); i++) begin
      n_checks++;
      if (beat_ptr[i] != ptrs[i] || beat_exp[i] != longint'(100 + i)) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: got ptr=%0d exp=%0d want %0d/%0d",
                 i, beat_ptr[i], beat_exp[i], ptrs[i], 100 + i);
      end
    end
    n_checks++;
    if (err_count !== 6'd0) begin
      n_fail++; $display("FAIL wrap_err_count: got %0d want 0", err_count);
    end
  endtask

  task automatic test_back_to_back();
    set_entry(2, 3, 10, 20, 30);
    out_ready = 1'b0;
    first_ptr = 5'd2;
    count     = 6'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_ptr !== 5'd2 || out_expected !== 64'd30 ||
          out_op_a !== 32'd10 || out_op_b !== 32'd20 || out_result !== 64'd30) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%0b ptr=%0d exp=%0d a=%0d want 1/2/30/10",
                 k, out_valid, out_ptr, out_expected, out_op_a);
      end
      if (k < 5) tick();
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_accept: got %0b want 0", out_valid);
    end
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ptr !== 5'd3 || out_expected !== 64'd4294967294) begin
      n_fail++;
      $display("FAIL stall_second: got v=%0b ptr=%0d exp=%0d want 1/3/4294967294",
               out_valid, out_ptr, out_expected);
    end
    tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL stall_done: got %0b want 1", done);
    end
    tick();
  endtask

  task automatic test_count_zero();
    bit got;
    first_ptr = 5'd9;
    count     = 6'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got done=%0b valid=%0b want 1/0", done, out_valid);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle: got done=%0b busy=%0b valid=%0b want 0/0/0",
               done, busy, out_valid);
    end
    set_entry(5, 1, 55, 0, 55);
    set_entry(6, 1, 66, 0, 66);
    out_ready = 1'b1;
    run_collect(5, 2, 1, got);
    n_checks++;
    if (!got || beat_ptr.size() != 2) begin
      n_fail++; $display("FAIL busy_start_beats: got %0d done=%0b want 2/1", beat_ptr.size(), got);
    end
    n_checks++;
    if (beat_ptr.size() == 2 && (beat_ptr[0] != 5 || beat_ptr[1] != 6)) begin
      n_fail++;
      $display("FAIL busy_start_ptrs: got %0d,%0d want 5,6", beat_ptr[0], beat_ptr[1]);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_idle: got %0b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    out_ready = 1'b0;
    first_ptr = 5'd7;
    count     = 6'd32;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ctl: got v=%0b busy=%0b done=%0b want 0/0/0",
               out_valid, busy, done);
    end
    n_checks++;
    if (read_pointer !== 5'd0 || out_ptr !== 5'd0 || out_expected !== 64'd0 ||
        err_count !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_mid_data: got rp=%0d ptr=%0d exp=%0d err=%0d want 0/0/0/0",
               read_pointer, out_ptr, out_expected, err_count);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_quiet%0d: got done=%0b busy=%0b want 0/0", k, done, busy);
      end
    end
    out_ready = 1'b1;
    run_collect(2, 1, -1, got);
    n_checks++;
    if (!got || beat_ptr.size() != 1) begin
      n_fail++; $display("FAIL rst_restart_beats: got %0d done=%0b want 1/1", beat_ptr.size(), got);
    end
    n_checks++;
    if (beat_ptr.size() == 1 && (beat_ptr[0] != 2 || beat_exp[0] != 30)) begin
      n_fail++;
      $display("FAIL rst_restart_beat: got ptr=%0d exp=%0d want 2/30", beat_ptr[0], beat_exp[0]);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    first_ptr = '0;
    count     = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) set_entry(i, 0, 0, 0, 0);
    test_reset();
    test_single_add();
    test_arith();
    test_wrap();
    test_back_to_back();
    test_count_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
